// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and game-key decoder.
// Synchronises and glitch-filters the raw PS/2 lines, deserialises 11-bit
// frames (start, 8 data LSB first, odd parity, stop), and tracks Set-2
// make/break/extended prefixes to produce held-key levels.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   ps2_clk    - raw PS/2 clock pin (asynchronous)
//   ps2_data   - raw PS/2 data pin (asynchronous)
//   key_space  - high while Space (29) is held
//   key_left   - high while Left arrow (E0 6B) is held
//   key_right  - high while Right arrow (E0 74) is held
//   byte_valid - one-cycle pulse per correctly received frame
//   byte_data  - last correctly received byte, held between pulses
//   frame_err  - one-cycle pulse on parity, stop-bit or timeout error
module ps2_key_decoder #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StBase, StExt, StBrk, StExtBrk} state_e;

  // Synchronisers; idle PS/2 lines are high, so reset to 1 to avoid a false edge.
  logic [1:0] clk_sync_q, data_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Clock filter: the filtered level follows only after FILTER_LEN consecutive
  // samples that differ from it.
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             filt_clk_q, filt_clk_d;
  logic             filt_prev_q;
  logic             fall;

  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_q  <= '0;
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      filt_cnt_q  <= filt_cnt_d;
      filt_clk_q  <= filt_clk_d;
      filt_prev_q <= filt_clk_q;
    end
  end

  assign fall = filt_prev_q & ~filt_clk_q;

  // Frame receiver and inter-edge timeout.
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       data_q, data_d;
  logic             timeout;
  logic             sdata;

  assign sdata = data_sync_q[1];

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    idle_d    = idle_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    data_d    = data_q;
    timeout   = 1'b0;
    if (fall) begin
      // A fall always beats a simultaneous timeout.
      idle_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is noise; stay waiting for a real start.
        if (!sdata) begin
          bit_cnt_d = 4'd1;
        end
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {sdata, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        parity_d  = sdata;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        if ((^{shift_q, parity_q}) && sdata) begin
          valid_d = 1'b1;
          data_d  = shift_q;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES)) begin
        timeout   = 1'b1;
        err_d     = 1'b1;
        bit_cnt_d = 4'd0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      idle_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      idle_q    <= idle_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  // Prefix tracker; advances on each received byte, key levels registered.
  state_e state_q, state_d;
  logic   space_q, space_d;
  logic   left_q, left_d;
  logic   right_q, right_d;

  always_comb begin
    state_d = state_q;
    space_d = space_q;
    left_d  = left_q;
    right_d = right_q;
    if (timeout) begin
      state_d = StBase;
    end else if (valid_q) begin
      unique case (state_q)
        StBase: begin
          if (data_q == 8'hE0) begin
            state_d = StExt;
          end else if (data_q == 8'hF0) begin
            state_d = StBrk;
          end else if (data_q == 8'h29) begin
            space_d = 1'b1;
          end
        end
        StExt: begin
          state_d = StBase;
          if (data_q == 8'hF0) begin
            state_d = StExtBrk;
          end else if (data_q == 8'h6B) begin
            left_d = 1'b1;
          end else if (data_q == 8'h74) begin
            right_d = 1'b1;
          end
        end
        StBrk: begin
          state_d = StBase;
          if (data_q == 8'h29) begin
            space_d = 1'b0;
          end
        end
        StExtBrk: begin
          state_d = StBase;
          if (data_q == 8'h6B) begin
            left_d = 1'b0;
          end else if (data_q == 8'h74) begin
            right_d = 1'b0;
          end
        end
        default: state_d = StBase;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBase;
      space_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      space_q <= space_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign key_space  = space_q;
  assign key_left   = left_q;
  assign key_right  = right_q;
  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: drives PS/2 frames on the raw
// pins and compares pulses, bytes and key levels against a reference model.
module tb_ps2_key_decoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 1000;
  localparam int unsigned HALF = 60;   // half PS/2 bit period in system cycles
  localparam int unsigned GAP  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_space, key_left, key_right, byte_valid, frame_err;
  logic [7:0] byte_data;

  ps2_key_decoder #(
    .CLK_FREQ      (100_000_000),
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_space (key_space),
    .key_left  (key_left),
    .key_right (key_right),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Monitor
  longint     cyc = 0;
  longint     fe_cyc = 0;
  longint     last_fall_cyc = 0;
  int         bv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  logic [2:0] keys_at = '0, keys_after = '0;
  logic       pend = 1'b0;
  logic [2:0] keys;

  assign keys = {key_space, key_left, key_right};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pend) begin
      keys_after <= keys;
      pend       <= 1'b0;
    end
    if (byte_valid) begin
      bv_cnt  <= bv_cnt + 1;
      keys_at <= keys;
      pend    <= 1'b1;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (byte_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  // Reference model: prefix flags and held keys derived from the scan-code rules.
  bit         m_ext = 0, m_brk = 0, m_space = 0, m_left = 0, m_right = 0;
  int         exp_bv = 0, exp_fe = 0;
  logic [7:0] exp_last = 8'h00;

  task automatic model_byte(input logic [7:0] b);
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'h29) m_space = 1;
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else begin
        if (b == 8'h6B) m_left = 1;
        else if (b == 8'h74) m_right = 1;
        m_ext = 0;
      end
    end else begin
      if (m_ext) begin
        if (b == 8'h6B) m_left = 0;
        else if (b == 8'h74) m_right = 0;
      end else if (b == 8'h29) m_space = 0;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_space = 0; m_left = 0; m_right = 0;
    exp_last = 8'h00;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par,
                                           input bit bad_stop);
    logic par;
    par = (~(^b)) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(mk_frame(b, bad_par, bad_stop), 11);
    ps2_data = 1'b1;
    wait_cyc(GAP);
    if (bad_par || bad_stop) exp_fe++;
    else begin
      exp_bv++;
      exp_last = b;
      model_byte(b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(4);
    checks++;
    if ({keys, byte_valid, byte_data, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %b, want all zero", {keys, byte_valid, byte_data,
               frame_err});
    end
    rst_n = 1'b1;
    wait_cyc(30);
    checks++;
    if (bv_cnt !== 0 || fe_cnt !== 0 || byte_data !== 8'h00 || keys !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: bv=%0d fe=%0d data=%h keys=%b, want 0 0 00 000", bv_cnt,
               fe_cnt, byte_data, keys);
    end
  endtask

  task automatic test_space();
    send_byte(8'h29, 0, 0);
    checks++;
    if (bv_cnt !== 1 || byte_data !== 8'h29) begin
      fails++;
      $display("FAIL space_make_byte: bv=%0d data=%h, want 1 29", bv_cnt, byte_data);
    end
    checks++;
    if (keys_at[2] !== 1'b0 || keys_after[2] !== 1'b1) begin
      fails++;
      $display("FAIL space_rise_timing: at_pulse=%b after=%b, want 0 1", keys_at[2],
               keys_after[2]);
    end
    send_byte(8'hF0, 0, 0);
    checks++;
    if (byte_data !== 8'hF0 || key_space !== 1'b1) begin
      fails++;
      $display("FAIL space_f0: data=%h space=%b, want F0 1", byte_data, key_space);
    end
    send_byte(8'h29, 0, 0);
    checks++;
    if (bv_cnt !== 3 || byte_data !== 8'h29 || keys_at[2] !== 1'b1 || keys_after[2] !== 1'b0)
    begin
      fails++;
      $display("FAIL space_break: bv=%0d data=%h at=%b after=%b, want 3 29 1 0", bv_cnt,
               byte_data, keys_at[2], keys_after[2]);
    end
  endtask

  task automatic test_arrows();
    logic [7:0] seq [12];
    logic [2:0] want [4];
    seq = '{8'hE0, 8'h6B, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h6B, 8'hE0, 8'hF0, 8'h74, 8'h00, 8'h00};
    want = '{3'b010, 3'b011, 3'b001, 3'b000};
    send_byte(seq[0], 0, 0); send_byte(seq[1], 0, 0);
    checks++;
    if (keys !== want[0]) begin
      fails++; $display("FAIL arrow_left_make: keys=%b want %b", keys, want[0]);
    end
    send_byte(seq[2], 0, 0); send_byte(seq[3], 0, 0);
    checks++;
    if (keys !== want[1]) begin
      fails++; $display("FAIL arrow_both_held: keys=%b want %b", keys, want[1]);
    end
    send_byte(seq[4], 0, 0); send_byte(seq[5], 0, 0); send_byte(seq[6], 0, 0);
    checks++;
    if (keys !== want[2]) begin
      fails++; $display("FAIL arrow_left_break: keys=%b want %b", keys, want[2]);
    end
    send_byte(seq[7], 0, 0); send_byte(seq[8], 0, 0); send_byte(seq[9], 0, 0);
    checks++;
    if (keys !== want[3] || bv_cnt !== exp_bv) begin
      fails++;
      $display("FAIL arrow_right_break: keys=%b bv=%0d want %b %0d", keys, bv_cnt, want[3],
               exp_bv);
    end
  endtask

  task automatic test_keypad();
    send_byte(8'h6B, 0, 0);
    checks++;
    if (byte_data !== 8'h6B || keys !== 3'b000 || bv_cnt !== exp_bv) begin
      fails++;
      $display("FAIL keypad_6b: data=%h keys=%b bv=%0d want 6b 000 %0d", byte_data, keys,
               bv_cnt, exp_bv);
    end
    // A bare 74 would set key_right only if the tracker had wrongly left base.
    send_byte(8'h74, 0, 0);
    checks++;
    if (keys !== 3'b000) begin
      fails++; $display("FAIL keypad_still_base: keys=%b want 000", keys);
    end
  endtask

  task automatic test_errors();
    send_byte(8'h29, 1, 0);
    checks++;
    if (fe_cnt !== exp_fe || bv_cnt !== exp_bv || byte_data !== 8'h74 || key_space !== 1'b0)
    begin
      fails++;
      $display("FAIL parity_err: fe=%0d bv=%0d data=%h space=%b want %0d %0d 74 0", fe_cnt,
               bv_cnt, byte_data, key_space, exp_fe, exp_bv);
    end
    send_byte(8'h29, 0, 0);
    checks++;
    if (key_space !== 1'b1 || byte_data !== 8'h29) begin
      fails++; $display("FAIL parity_recover: space=%b data=%h want 1 29", key_space, byte_data);
    end
    send_byte(8'hF0, 0, 1);
    checks++;
    if (fe_cnt !== exp_fe || key_space !== 1'b1 || byte_data !== 8'h29) begin
      fails++;
      $display("FAIL stop_err: fe=%0d space=%b data=%h want %0d 1 29", fe_cnt, key_space,
               byte_data, exp_fe);
    end
    send_byte(8'hF0, 0, 0);
    send_byte(8'h29, 0, 0);
    checks++;
    if (key_space !== 1'b0) begin
      fails++; $display("FAIL stop_err_then_break: space=%b want 0", key_space);
    end
  endtask

  task automatic test_timeout();
    int   fe0;
    longint dt;
    send_byte(8'hE0, 0, 0);
    fe0 = fe_cnt;
    send_bits(mk_frame(8'h6B, 0, 0), 4);
    wait_cyc(2 * TO);
    exp_fe++;
    m_ext = 0;
    m_brk = 0;
    dt = fe_cyc - last_fall_cyc;
    checks++;
    if (fe_cnt !== fe0 + 1 || dt < TO + 6 || dt > TO + 20) begin
      fails++;
      $display("FAIL timeout_pulse: pulses=%0d delay=%0d want 1 in [%0d,%0d]", fe_cnt - fe0,
               dt, TO + 6, TO + 20);
    end
    send_byte(8'h6B, 0, 0);
    checks++;
    if (keys !== 3'b000 || byte_data !== 8'h6B || bv_cnt !== exp_bv) begin
      fails++;
      $display("FAIL timeout_base: keys=%b data=%h bv=%0d want 000 6b %0d", keys, byte_data,
               bv_cnt, exp_bv);
    end
  endtask

  task automatic test_reset_mid();
    int bv0, fe0;
    send_byte(8'hE0, 0, 0);
    send_byte(8'h6B, 0, 0);
    checks++;
    if (key_left !== 1'b1) begin
      fails++; $display("FAIL rst_setup_left: left=%b want 1", key_left);
    end
    send_bits(mk_frame(8'h29, 0, 0), 5);
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({keys, byte_valid, byte_data, frame_err} !== 12'h000) begin
      fails++;
      $display("FAIL rst_async_clear: got %b want all zero", {keys, byte_valid, byte_data,
               frame_err});
    end
    wait_cyc(3);
    rst_n = 1'b1;
    model_reset();
    wait_cyc(3 * TO);
    checks++;
    if (bv_cnt !== bv0 || fe_cnt !== fe0) begin
      fails++;
      $display("FAIL rst_no_pulse: bv+%0d fe+%0d want +0 +0", bv_cnt - bv0, fe_cnt - fe0);
    end
    send_byte(8'h29, 0, 0);
    checks++;
    if (keys !== 3'b100 || byte_data !== 8'h29) begin
      fails++; $display("FAIL rst_then_space: keys=%b data=%h want 100 29", keys, byte_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8];
    logic [7:0] b;
    int         e;
    pool = '{8'hE0, 8'hF0, 8'h29, 8'h6B, 8'h74, 8'hAA, 8'hE1, 8'h00};
    bv_cnt = bv_cnt;  // counters continue; expectations are absolute
    for (int i = 0; i < 14; i++) begin
      b = pool[$urandom_range(0, 7)];
      if (b == 8'h00) b = 8'($urandom);
      e = $urandom_range(0, 7);
      send_byte(b, e == 0, e == 1);
      checks++;
      if (bv_cnt !== exp_bv || fe_cnt !== exp_fe || byte_data !== exp_last ||
          keys !== {m_space, m_left, m_right}) begin
        fails++;
        $display("FAIL random_%0d byte=%h err=%0d: bv=%0d fe=%0d data=%h keys=%b want %0d %0d %h %b",
                 i, b, e, bv_cnt, fe_cnt, byte_data, keys, exp_bv, exp_fe, exp_last,
                 {m_space, m_left, m_right});
      end
    end
  endtask

  task automatic test_back_to_back();
    send_bits(mk_frame(8'hE0, 0, 0), 11);
    send_bits(mk_frame(8'h74, 0, 0), 11);
    ps2_data = 1'b1;
    wait_cyc(GAP);
    exp_bv += 2;
    exp_last = 8'h74;
    model_byte(8'hE0);
    model_byte(8'h74);
    checks++;
    if (bv_cnt !== exp_bv || key_right !== 1'b1 || keys !== {m_space, m_left, m_right}) begin
      fails++;
      $display("FAIL back_to_back: bv=%0d keys=%b want %0d %b", bv_cnt, keys, exp_bv,
               {m_space, m_left, m_right});
    end
    checks++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL valid_err_overlap: cycles=%0d want 0", both_cnt);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_space();
    test_arrows();
    test_keypad();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
